// File: rtl/uart_msg_tx.sv
// Response framer for the UART command link: control responses and golden-nonce reports.
// Define UART_MSG_TX_NONCE_FIFO_EN to queue nonces in a FIFO instead of a single holding register.
module uart_msg_tx #(
  parameter logic [7:0]  NONCE_TYPE       = 8'h03,
  parameter int unsigned NONCE_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic        msg_short,
  input  logic [7:0]  msg_type,
  input  logic [1:0]  msg_nwords,
  input  logic [95:0] msg_payload,
  input  logic        nonce_valid,
  input  logic [31:0] nonce,
  output logic        nonce_overflow,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHORT = 2'd1, HDR = 2'd2, PAY = 2'd3} state_t;

  if ((NONCE_FIFO_DEPTH < 32'd2) || ((NONCE_FIFO_DEPTH & (NONCE_FIFO_DEPTH - 32'd1)) != 32'd0)) begin : g_depth_check
    $error("NONCE_FIFO_DEPTH must be a power of 2 and at least 2");
  end

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [1:0] nwords,
                                          input logic [7:0] typ);
    logic [7:0] res;
    case (idx)
      2'd0:    res = 8'd4 + {4'b0000, nwords, 2'b00};
      2'd3:    res = typ;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  function automatic logic [7:0] pay_byte(input logic [95:0] pay, input logic [3:0] idx);
    return pay[{idx, 3'b000} +: 8];
  endfunction

  state_t      state_r, state_nxt_s;
  logic [3:0]  idx_r, idx_nxt_s;
  logic [7:0]  typ_r, typ_nxt_s;
  logic [1:0]  nwords_r, nwords_nxt_s;
  logic [95:0] payload_r, payload_nxt_s;
  logic [7:0]  tx_data_r, tx_data_nxt_s;
  logic        tx_valid_r, tx_valid_nxt_s;
  logic        msg_ready_r, busy_r, overflow_r;
  logic        msg_ready_s, hs_s, deq_s;
  logic [3:0]  last_idx_s;
  logic        pending_s, pending_nxt_s, wr_s, drop_s;
  logic [31:0] head_s;

`ifdef UART_MSG_TX_NONCE_FIFO_EN
  localparam int unsigned AW = $clog2(NONCE_FIFO_DEPTH);

  logic [31:0] fifo_r [NONCE_FIFO_DEPTH];
  logic [AW:0] wr_ptr_r, rd_ptr_r, count_s;

  assign count_s       = wr_ptr_r - rd_ptr_r;
  assign pending_s     = (count_s != {(AW+1){1'b0}});
  assign head_s        = fifo_r[rd_ptr_r[AW-1:0]];
  // A full FIFO still takes a nonce when the head leaves in the same cycle.
  assign wr_s          = nonce_valid & ((count_s != (AW+1)'(NONCE_FIFO_DEPTH)) | deq_s);
  assign drop_s        = nonce_valid & ~wr_s;
  assign pending_nxt_s = wr_s | (count_s > {{AW{1'b0}}, 1'b1}) | (pending_s & ~deq_s);

  // Nonce FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NONCE_FIFO_DEPTH); i++) fifo_r[i] <= 32'h0;
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_s) fifo_r[wr_ptr_r[AW-1:0]] <= nonce;
      wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, wr_s};
      rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, deq_s};
    end
  end
`else
  logic [31:0] hold_r;
  logic        hold_valid_r;

  assign pending_s     = hold_valid_r;
  assign head_s        = hold_r;
  assign wr_s          = nonce_valid & (~hold_valid_r | deq_s);
  assign drop_s        = nonce_valid & ~wr_s;
  assign pending_nxt_s = wr_s | (hold_valid_r & ~deq_s);

  // Single nonce holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r       <= 32'h0;
      hold_valid_r <= 1'b0;
    end else begin
      if (wr_s) hold_r <= nonce;
      hold_valid_r <= pending_nxt_s;
    end
  end
`endif

  // A nonce pulse blocks the request in the same cycle so the nonce wins.
  assign msg_ready_s = msg_ready_r & ~nonce_valid;
  assign hs_s        = tx_valid_r & tx_ready;
  assign last_idx_s  = {nwords_r, 2'b00} - 4'd1;

  // Frame sequencer: next state and next presented byte.
  always_comb begin
    state_nxt_s    = state_r;
    idx_nxt_s      = idx_r;
    typ_nxt_s      = typ_r;
    nwords_nxt_s   = nwords_r;
    payload_nxt_s  = payload_r;
    tx_data_nxt_s  = tx_data_r;
    tx_valid_nxt_s = tx_valid_r;
    deq_s          = 1'b0;
    case (state_r)
      IDLE: begin
        if (pending_s) begin
          deq_s          = 1'b1;
          state_nxt_s    = HDR;
          idx_nxt_s      = 4'd0;
          typ_nxt_s      = NONCE_TYPE;
          nwords_nxt_s   = 2'd1;
          payload_nxt_s  = {64'h0, head_s};
          tx_data_nxt_s  = hdr_byte(2'd0, 2'd1, NONCE_TYPE);
          tx_valid_nxt_s = 1'b1;
        end else if (msg_valid && msg_ready_s) begin
          idx_nxt_s      = 4'd0;
          typ_nxt_s      = msg_type;
          nwords_nxt_s   = msg_nwords;
          payload_nxt_s  = msg_payload;
          tx_valid_nxt_s = 1'b1;
          if (msg_short) begin
            state_nxt_s   = SHORT;
            tx_data_nxt_s = msg_type;
          end else begin
            state_nxt_s   = HDR;
            tx_data_nxt_s = hdr_byte(2'd0, msg_nwords, msg_type);
          end
        end else begin
          tx_valid_nxt_s = 1'b0;
        end
      end
      SHORT: begin
        if (hs_s) begin
          state_nxt_s    = IDLE;
          tx_valid_nxt_s = 1'b0;
        end else begin
          tx_valid_nxt_s = 1'b1;
        end
      end
      HDR: begin
        if (hs_s) begin
          if (idx_r == 4'd3) begin
            if (nwords_r == 2'd0) begin
              state_nxt_s    = IDLE;
              tx_valid_nxt_s = 1'b0;
            end else begin
              state_nxt_s   = PAY;
              idx_nxt_s     = 4'd0;
              tx_data_nxt_s = pay_byte(payload_r, 4'd0);
            end
          end else begin
            idx_nxt_s     = idx_r + 4'd1;
            tx_data_nxt_s = hdr_byte(idx_r[1:0] + 2'd1, nwords_r, typ_r);
          end
        end else begin
          tx_valid_nxt_s = 1'b1;
        end
      end
      PAY: begin
        if (hs_s) begin
          if (idx_r == last_idx_s) begin
            state_nxt_s    = IDLE;
            tx_valid_nxt_s = 1'b0;
          end else begin
            idx_nxt_s     = idx_r + 4'd1;
            tx_data_nxt_s = pay_byte(payload_r, idx_r + 4'd1);
          end
        end else begin
          tx_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        tx_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= 4'd0;
      typ_r       <= 8'h00;
      nwords_r    <= 2'd0;
      payload_r   <= 96'h0;
      tx_data_r   <= 8'h00;
      tx_valid_r  <= 1'b0;
      msg_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      typ_r       <= typ_nxt_s;
      nwords_r    <= nwords_nxt_s;
      payload_r   <= payload_nxt_s;
      tx_data_r   <= tx_data_nxt_s;
      tx_valid_r  <= tx_valid_nxt_s;
      msg_ready_r <= (state_nxt_s == IDLE) & ~pending_nxt_s;
      busy_r      <= (state_nxt_s != IDLE) | pending_nxt_s;
      overflow_r  <= overflow_r | drop_s;
    end
  end

  assign msg_ready      = msg_ready_s;
  assign tx_data        = tx_data_r;
  assign tx_valid       = tx_valid_r;
  assign busy           = busy_r;
  assign nonce_overflow = overflow_r;

endmodule
